// File: rtl/corr_pkg.sv
// Shared types and constants for the correlator window sequencer and its LFSR.
package corr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Two spare bits so 2^P plus the widest jitter can never wrap the counter.
    function automatic int period_cnt_width(input int period_exp, input int jitter_exp);
        return ((period_exp > jitter_exp) ? period_exp : jitter_exp) + 2;
    endfunction

    function automatic int sample_cnt_width(input int window_exp);
        return window_exp + 1;
    endfunction

endpackage

// File: rtl/corr_lfsr16.sv
// 16-bit Galois LFSR that supplies the strobe jitter; steps once per emitted strobe.
module corr_lfsr16
    import corr_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cg,
    input  logic        i_step,
    output logic [15:0] o_state
);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_state <= LFSR_SEED;
        end else if (i_cg && i_step) begin
            o_state <= (o_state >> 1) ^ (o_state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/corr_window_sequencer.sv
// Sample sequencer for one correlator engine: jittered strobes grouped into
// 2^W-sample windows, with a valid/ready completed-window flag and sticky overrun.
module corr_window_sequencer
    import corr_pkg::*;
#(
    parameter int MAX_WINDOW_LENGTH_EXP = 16,
    parameter int MAX_SAMPLE_PERIOD_EXP = 15,
    parameter int MAX_SAMPLE_JITTER_EXP = 8
) (
    input  logic                                         i_clk,
    input  logic                                         i_rst,
    input  logic                                         i_cg,
    input  logic                                         i_enable,
    input  logic [$clog2(MAX_WINDOW_LENGTH_EXP+1)-1:0]   i_windowLengthExp,
    input  logic [$clog2(MAX_SAMPLE_PERIOD_EXP+1)-1:0]   i_samplePeriodExp,
    input  logic [$clog2(MAX_SAMPLE_JITTER_EXP+1)-1:0]   i_sampleJitterExp,
    input  logic                                         i_resultReady,
    output logic                                         o_sampleStrobe,
    output logic                                         o_windowStart,
    output logic                                         o_windowEnd,
    output logic                                         o_resultValid,
    output logic                                         o_overrun,
    output logic                                         o_busy
);

    localparam int WE_W     = $clog2(MAX_WINDOW_LENGTH_EXP + 1);
    localparam int PE_W     = $clog2(MAX_SAMPLE_PERIOD_EXP + 1);
    localparam int JE_W     = $clog2(MAX_SAMPLE_JITTER_EXP + 1);
    localparam int PERIOD_W = period_cnt_width(MAX_SAMPLE_PERIOD_EXP, MAX_SAMPLE_JITTER_EXP);
    localparam int SAMPLE_W = sample_cnt_width(MAX_WINDOW_LENGTH_EXP);

    state_t              state, state_next;
    logic [PERIOD_W-1:0] period_cnt, period_next;
    logic [SAMPLE_W-1:0] sample_cnt, sample_next, sample_inc;
    logic [WE_W-1:0]     w_cfg, w_lat, w_eff;
    logic [PE_W-1:0]     p_cfg, p_lat, p_eff;
    logic [JE_W-1:0]     j_cfg, j_lat, j_eff;
    logic [15:0]         lfsr, jitter_mask;
    logic                strobe, win_start, win_end;
    logic                result_valid, overrun;

    corr_lfsr16 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_cg    (i_cg),
        .i_step  (strobe),
        .o_state (lfsr)
    );

    always_comb begin
        w_cfg = i_windowLengthExp;
        p_cfg = i_samplePeriodExp;
        j_cfg = i_sampleJitterExp;
        if (i_windowLengthExp > WE_W'(MAX_WINDOW_LENGTH_EXP)) w_cfg = WE_W'(MAX_WINDOW_LENGTH_EXP);
        if (i_samplePeriodExp > PE_W'(MAX_SAMPLE_PERIOD_EXP)) p_cfg = PE_W'(MAX_SAMPLE_PERIOD_EXP);
        if (i_sampleJitterExp > JE_W'(MAX_SAMPLE_JITTER_EXP)) j_cfg = JE_W'(MAX_SAMPLE_JITTER_EXP);
    end

    // The first strobe of a window uses the live configuration and latches it for the rest.
    always_comb begin
        state_next  = state;
        period_next = period_cnt;
        sample_next = sample_cnt;
        strobe      = 1'b0;
        win_start   = 1'b0;
        win_end     = 1'b0;
        w_eff       = w_lat;
        p_eff       = p_lat;
        j_eff       = j_lat;
        jitter_mask = '0;
        sample_inc  = sample_cnt + SAMPLE_W'(1);
        unique case (state)
            IDLE: begin
                if (i_enable) state_next = RUN;
            end
            RUN: begin
                if (period_cnt == '0) begin
                    strobe    = 1'b1;
                    win_start = (sample_cnt == '0);
                    if (win_start) begin
                        w_eff = w_cfg;
                        p_eff = p_cfg;
                        j_eff = j_cfg;
                    end
                    win_end     = (sample_inc == (SAMPLE_W'(1) << w_eff));
                    sample_next = win_end ? '0 : sample_inc;
                    jitter_mask = (16'd1 << j_eff) - 16'd1;
                    period_next = (PERIOD_W'(1) << p_eff) + PERIOD_W'(lfsr & jitter_mask) - PERIOD_W'(1);
                end else begin
                    period_next = period_cnt - PERIOD_W'(1);
                end
                // Abort: the current strobe still goes out, the partial window is dropped.
                if (!i_enable) begin
                    state_next  = IDLE;
                    period_next = '0;
                    sample_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (!i_cg) begin
            strobe    = 1'b0;
            win_start = 1'b0;
            win_end   = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else if (i_cg) begin
            state <= state_next;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            period_cnt <= '0;
            sample_cnt <= '0;
            w_lat      <= '0;
            p_lat      <= '0;
            j_lat      <= '0;
        end else if (i_cg) begin
            period_cnt <= period_next;
            sample_cnt <= sample_next;
            if (win_start) begin
                w_lat <= w_eff;
                p_lat <= p_eff;
                j_lat <= j_eff;
            end
        end
    end

    // A new result arriving alongside an accept simply replaces the old one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else if (i_cg) begin
            if (win_end) begin
                result_valid <= 1'b1;
                if (result_valid && !i_resultReady) overrun <= 1'b1;
            end else if (result_valid && i_resultReady) begin
                result_valid <= 1'b0;
            end
            if (state == IDLE && state_next == RUN) overrun <= 1'b0;
        end
    end

    assign o_sampleStrobe = strobe;
    assign o_windowStart  = win_start;
    assign o_windowEnd    = win_end;
    assign o_resultValid  = result_valid;
    assign o_overrun      = overrun;
    assign o_busy         = (state == RUN);

endmodule

// File: tb/tb_corr_window_sequencer.sv
// Self-checking bench for corr_window_sequencer: directed scenarios plus random
// traffic, compared every cycle against a timestamp-based behavioural model.
module tb_corr_window_sequencer;

    logic       clk;
    logic       rst, en, cg, ready;
    logic [4:0] w_cfg;
    logic [3:0] p_cfg, j_cfg;
    logic       strobe_o, start_o, end_o, valid_o, overrun_o, busy_o;

    int checks = 0;
    int failures = 0;

    // Model: strobes are due at absolute enabled-cycle timestamps.
    bit          m_run, m_valid, m_overrun;
    int          m_t, m_due, m_k, m_wl, m_pl, m_jl;
    logic [15:0] m_lfsr;

    bit seen_strobe, seen_start, seen_end;
    int cyc, last_strobe, gap, strobe_n, end_n;
    bit found;

    corr_window_sequencer dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_cg              (cg),
        .i_enable          (en),
        .i_windowLengthExp (w_cfg),
        .i_samplePeriodExp (p_cfg),
        .i_sampleJitterExp (j_cfg),
        .i_resultReady     (ready),
        .o_sampleStrobe    (strobe_o),
        .o_windowStart     (start_o),
        .o_windowEnd       (end_o),
        .o_resultValid     (valid_o),
        .o_overrun         (overrun_o),
        .o_busy            (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_run = 0; m_valid = 0; m_overrun = 0;
        m_t = 0; m_due = 0; m_k = 0;
        m_wl = 0; m_pl = 0; m_jl = 0;
        m_lfsr = 16'hACE1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle with the inputs currently driven; entered and left at negedge.
    task automatic applyStimulus();
        bit e_strobe, e_start, e_end;
        int wl, pl, jl;
        #2;
        e_strobe = m_run && cg && (m_t == m_due);
        wl = m_wl; pl = m_pl; jl = m_jl;
        if (e_strobe && m_k == 0) begin
            wl = clamp(int'(w_cfg), 16);
            pl = clamp(int'(p_cfg), 15);
            jl = clamp(int'(j_cfg), 8);
        end
        e_start = e_strobe && (m_k == 0);
        e_end   = e_strobe && (m_k == (1 << wl) - 1);
        checkOutput("strobe",  32'(strobe_o),  32'(e_strobe));
        checkOutput("start",   32'(start_o),   32'(e_start));
        checkOutput("end",     32'(end_o),     32'(e_end));
        checkOutput("valid",   32'(valid_o),   32'(m_valid));
        checkOutput("overrun", 32'(overrun_o), 32'(m_overrun));
        checkOutput("busy",    32'(busy_o),    32'(m_run));
        seen_strobe = strobe_o; seen_start = start_o; seen_end = end_o;
        if (seen_strobe) begin
            strobe_n++;
            gap = cyc - last_strobe;
            last_strobe = cyc;
        end
        if (seen_end) end_n++;
        cyc++;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (cg) begin
            if (e_strobe) begin
                m_wl = wl; m_pl = pl; m_jl = jl;
                m_due = m_t + (1 << pl) + (int'(m_lfsr) & ((1 << jl) - 1));
                m_lfsr = lfsr_next(m_lfsr);
                m_k = e_end ? 0 : m_k + 1;
            end
            if (e_end) begin
                if (m_valid && !ready) m_overrun = 1;
                m_valid = 1;
            end else if (m_valid && ready) begin
                m_valid = 0;
            end
            if (m_run) begin
                m_t++;
                if (!en) begin m_run = 0; m_k = 0; end
            end else if (en) begin
                m_run = 1; m_t = 0; m_due = 0; m_k = 0; m_overrun = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; cg = 1; ready = 0;
        applyStimulus();
        rst = 0;
        strobe_n = 0; end_n = 0;
    endtask

    initial begin
        rst = 1; en = 0; cg = 1; ready = 0;
        w_cfg = '0; p_cfg = '0; j_cfg = '0;
        cyc = 0; last_strobe = 0; gap = 0; strobe_n = 0; end_n = 0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        #1;
        checkOutput("rst_strobe",  32'(strobe_o),  32'd0);
        checkOutput("rst_start",   32'(start_o),   32'd0);
        checkOutput("rst_end",     32'(end_o),     32'd0);
        checkOutput("rst_valid",   32'(valid_o),   32'd0);
        checkOutput("rst_overrun", 32'(overrun_o), 32'd0);
        checkOutput("rst_busy",    32'(busy_o),    32'd0);
        rst = 0;

        // W=2 P=3 J=0: strobes every 8 cycles, windows of 4
        $display("[TB] scenario A: W=2 P=3 J=0");
        w_cfg = 5'd2; p_cfg = 4'd3; j_cfg = 4'd0; ready = 1; en = 1; strobe_n = 0;
        for (int i = 0; i < 75; i++) begin
            applyStimulus();
            if (seen_strobe) begin
                checkOutput("A_start_idx", 32'(seen_start), 32'((strobe_n % 4) == 1));
                checkOutput("A_end_idx",   32'(seen_end),   32'((strobe_n % 4) == 0));
                if (strobe_n > 1) checkOutput("A_gap", 32'(gap), 32'd8);
            end
        end
        checkOutput("A_strobe_count", 32'(strobe_n), 32'd10);

        // W=0 P=0 J=0: every cycle is a strobe, start and end
        $display("[TB] scenario B: W=0 P=0 J=0");
        do_reset();
        w_cfg = 5'd0; p_cfg = 4'd0; j_cfg = 4'd0; ready = 1; en = 1;
        applyStimulus();
        for (int i = 0; i < 20; i++) begin
            applyStimulus();
            checkOutput("B_all_high", 32'(seen_strobe && seen_start && seen_end), 32'd1);
        end
        checkOutput("B_valid", 32'(valid_o), 32'd1);

        // P=2 J=2: jittered intervals from the reset seed
        $display("[TB] scenario C: P=2 J=2");
        do_reset();
        w_cfg = 5'd3; p_cfg = 4'd2; j_cfg = 4'd2; ready = 1; en = 1;
        for (int i = 0; i < 80; i++) begin
            applyStimulus();
            if (seen_strobe && strobe_n > 1)
                checkOutput("C_gap_range", 32'(gap >= 4 && gap <= 7), 32'd1);
        end

        // W=1 P=1 with the reader stalled: overrun, then re-enable clears it
        $display("[TB] scenario D: overrun");
        do_reset();
        w_cfg = 5'd1; p_cfg = 4'd1; j_cfg = 4'd0; ready = 0; en = 1;
        repeat (12) applyStimulus();
        checkOutput("D_overrun_set", 32'(overrun_o), 32'd1);
        ready = 1;
        applyStimulus();
        ready = 0;
        checkOutput("D_valid_clr", 32'(valid_o), 32'd0);
        checkOutput("D_overrun_hold", 32'(overrun_o), 32'd1);
        en = 0;
        repeat (3) applyStimulus();
        checkOutput("D_overrun_idle", 32'(overrun_o), 32'd1);
        en = 1;
        repeat (2) applyStimulus();
        checkOutput("D_overrun_clr", 32'(overrun_o), 32'd0);

        // Abort after 3 of 4 strobes
        $display("[TB] scenario E: abort");
        do_reset();
        w_cfg = 5'd2; p_cfg = 4'd1; j_cfg = 4'd0; ready = 1; en = 1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            applyStimulus();
            if (strobe_n == 3) found = 1;
        end
        checkOutput("E_third_strobe", 32'(found), 32'd1);
        en = 0; end_n = 0;
        repeat (4) applyStimulus();
        checkOutput("E_busy", 32'(busy_o), 32'd0);
        checkOutput("E_no_end", 32'(end_n), 32'd0);
        en = 1;
        applyStimulus();
        applyStimulus();
        checkOutput("E_restart", 32'(seen_start && seen_strobe), 32'd1);

        // Clock gate for 5 cycles mid-interval defers the strobe
        $display("[TB] scenario F: clock gate");
        do_reset();
        w_cfg = 5'd3; p_cfg = 4'd3; j_cfg = 4'd0; ready = 1; en = 1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus();
            if (strobe_n == 2) found = 1;
        end
        checkOutput("F_second_strobe", 32'(found), 32'd1);
        repeat (3) applyStimulus();
        cg = 0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput("F_gap_quiet", 32'(seen_strobe || seen_start || seen_end), 32'd0);
        end
        cg = 1;
        found = 0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus();
            if (seen_strobe) found = 1;
        end
        checkOutput("F_found", 32'(found), 32'd1);
        checkOutput("F_gap", 32'(gap), 32'd13);

        // Jitter exponent above its maximum clamps to 8
        $display("[TB] scenario G: jitter clamp");
        do_reset();
        w_cfg = 5'd0; p_cfg = 4'd0; j_cfg = 4'd12; ready = 1; en = 1;
        repeat (400) applyStimulus();

        // Random traffic
        $display("[TB] scenario R: random");
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if (c % 37 == 0) begin
                w_cfg = 5'($urandom_range(0, 3));
                p_cfg = 4'($urandom_range(0, 3));
                j_cfg = 4'($urandom_range(0, 4));
            end
            en    = ($urandom_range(0, 59) != 0);
            cg    = ($urandom_range(0, 9) != 0);
            ready = 1'($urandom_range(0, 1));
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/corr_window_sequencer.md
Name: corr_window_sequencer

Overview:
- Sequences sampling for one correlator engine: emits a jittered sample strobe, groups strobes into windows of 2^W samples, and flags each completed window to the result reader.
- Sits between the USB-side configuration registers and the engine's sample/accumulate datapath; one instance per engine.
- Result handshake is valid/ready, with a sticky overrun flag when the reader falls behind.

Parameters:
- MAX_WINDOW_LENGTH_EXP, 16, max log2 of samples per window.
- MAX_SAMPLE_PERIOD_EXP, 15, max log2 of the base strobe interval in cycles.
- MAX_SAMPLE_JITTER_EXP, 8, max log2 of the jitter range; must be <= 16.

Ports:
- i_clk  in  1  engine clock (48MHz domain).
- i_rst  in  1  synchronous active-high reset.
- i_cg  in  1  cycle enable; 0 freezes all state and forces pulse outputs to 0.
- i_enable  in  1  run request, level-sensitive.
- i_windowLengthExp  in  $clog2(MAX_WINDOW_LENGTH_EXP+1)  W.
- i_samplePeriodExp  in  $clog2(MAX_SAMPLE_PERIOD_EXP+1)  P.
- i_sampleJitterExp  in  $clog2(MAX_SAMPLE_JITTER_EXP+1)  J.
- i_resultReady  in  1  reader accepts the completed window.
- o_sampleStrobe  out  1  one-cycle pulse: engine samples probes.
- o_windowStart  out  1  one-cycle pulse on the first strobe of a window.
- o_windowEnd  out  1  one-cycle pulse on the last strobe of a window.
- o_resultValid  out  1  a completed window awaits the reader.
- o_overrun  out  1  sticky: a window completed while the previous result was unread.
- o_busy  out  1  state is RUN.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; counters 0.
  - LFSR = 16'hACE1.
- Config:
  - W, P and J are each clamped to their MAX parameter.
  - All three are latched on every window start; mid-window changes are ignored.
- LFSR:
  - 16-bit Galois, mask 16'hB400.
  - Advances one step per emitted strobe, only when i_cg=1.
- Strobe interval:
  - Interval = 2^P + j cycles, where j = lfsr[J-1:0] (j=0 when J=0), sampled at each strobe.
  - Period counter width is max(MAX_SAMPLE_PERIOD_EXP, MAX_SAMPLE_JITTER_EXP)+2; no wrap is possible.
  - P=0, J=0 gives a strobe every cycle.
- IDLE:
  - Transitions to RUN in the cycle after i_enable=1 is sampled.
  - On entry to RUN: o_windowStart=1 and o_sampleStrobe=1 in the same cycle; o_overrun cleared.
- RUN, per-window sample counter (width MAX_WINDOW_LENGTH_EXP+1):
  - Counts strobes in the current window.
  - The 2^W-th strobe asserts o_windowEnd with that strobe.
  - The next strobe, after the normal interval, asserts o_windowStart and starts a new window. Windows are back-to-back.
  - W=0: o_windowStart and o_windowEnd are both asserted on every strobe.
- Result handshake:
  - o_resultValid sets the cycle after o_windowEnd.
  - It clears the cycle after o_resultValid && i_resultReady.
  - If o_windowEnd fires while o_resultValid=1 and no accept occurs that cycle: o_overrun sets, and o_resultValid stays 1.
  - An accept in the same cycle as o_windowEnd is not an overrun.
- Abort:
  - i_enable=0 sampled in RUN returns to IDLE next cycle.
  - The partial window is discarded: no o_windowEnd, counters zeroed.
  - o_resultValid and o_overrun hold their values.
  - The LFSR is not reseeded.
- Simultaneous events:
  - i_enable falling on a strobe cycle: that strobe is still emitted.
  - i_rst wins over everything.
- i_cg=0:
  - No counter, LFSR or FSM change.
  - Pulses are masked; level outputs hold.
  - The strobe is deferred, not lost.
- FSM has two states, IDLE and RUN; o_busy = (state==RUN).

Decomposition:
- Package corr_pkg holds:
  - state enum (IDLE, RUN);
  - LFSR_SEED (16'hACE1);
  - LFSR_TAPS (16'hB400);
  - a width helper function for the counter widths.
- One natural sub-module: corr_lfsr16, with i_clk, i_rst, i_cg, i_step, o_state.
- Everything else is inline.

Test Plan:
- W=2, P=3, J=0, enable held -> strobes every 8 cycles; windowStart on strobes 1, 5, 9; windowEnd on strobes 4, 8; resultValid the cycle after each windowEnd.
- W=0, P=0, J=0 -> strobe, windowStart and windowEnd all high every cycle; resultValid stays 1 with i_resultReady=1 tied.
- P=2, J=2 after reset -> first intervals equal 4 + (lfsr&3) following seed 16'hACE1 per reference model; no interval below 4 or above 7.
- W=1, P=1, i_resultReady=0 -> second windowEnd sets o_overrun; ready pulse clears resultValid but overrun stays until re-enable.
- Deassert i_enable mid-window (after 3 of 4 strobes) -> IDLE next cycle, no windowEnd, o_busy=0; re-enable -> windowStart on first cycle of RUN, overrun cleared.
- i_cg=0 for 5 cycles mid-interval with P=3 -> strobe delayed by exactly 5 cycles; no pulses during the gap.
